// File: rtl/i2s_pkg.sv
// Shared constants, register map and FSM encoding for the I2S capture block.
package i2s_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int PAIR_W     = 2 * SAMPLE_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int BITCNT_W   = $clog2(SAMPLE_W);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEFT   = 2'd1;
    localparam logic [1:0] REG_RIGHT  = 2'd2;
    localparam logic [1:0] REG_FRAMES = 2'd3;

    // Control/status bit positions in register 0.
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_OVF      = 1;
    localparam int CTRL_FERR     = 2;
    localparam int CTRL_FLUSH    = 3;
    localparam int STAT_FILL_LSB = 3;
    localparam int STAT_EMPTY    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } rx_state_t;

    function automatic logic [31:0] left_justify(input logic [SAMPLE_W-1:0] sample);
        return {sample, {(32 - SAMPLE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Processor register bus for the I2S capture block.
// ram_read/ram_write are single-cycle strobes qualified by ram_address; there is no
// wait state, a write lands on the clock edge of its strobe and ram_readdata is
// valid combinationally in the same cycle as ram_address.
interface i2s_rx_if;
    logic [1:0]  ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    modport master (
        output ram_address, ram_read, ram_write, ram_writedata,
        input  ram_readdata
    );

    modport slave (
        input  ram_address, ram_read, ram_write, ram_writedata,
        output ram_readdata
    );
endinterface

// File: rtl/i2s_rx_stereo_fifo.sv
// Synchronous FIFO of left/right sample pairs; flush beats push and pop in the same cycle.
module stereo_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = PAIR_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         push_ok,
    output logic                         drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign drop    = push && !flush && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: resynchronises SCLK/LRCLK/Din, deserialises 24-bit stereo pairs into
// a FIFO and exposes them left-justified on a 2-bit-address register bus.
module i2s_rx
    import i2s_pkg::*;
(
    input  logic      CLK,
    input  logic      RESET,
    input  logic      SCLK,
    input  logic      LRCLK,
    input  logic      Din,
    i2s_rx_if.slave   bus,
    output rx_state_t fsm_state
);

    logic sclk_s1, sclk_s2, sclk_s3;
    logic lr_s1, lr_s2;
    logic din_s1, din_s2;
    logic lr_prev;
    logic sclk_rise;
    logic lr_edge;

    rx_state_t             state, state_next;
    logic [BITCNT_W-1:0]   bitcnt;
    logic [SAMPLE_W-1:0]   sr;
    logic [SAMPLE_W-1:0]   word;
    logic [SAMPLE_W-1:0]   left_hold;
    logic                  left_valid;
    logic                  push_req;
    logic                  shift_en;
    logic                  clear_bitcnt;
    logic                  word_done;
    logic                  truncate;

    logic        enable;
    logic        ovf;
    logic        ferr;
    logic [31:0] frames;
    logic        ctrl_wr;
    logic        flush;
    logic        pop;

    logic [PAIR_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_push_ok;
    logic              fifo_drop;
    logic              unused_wdata;

    // Synchronisers; the third SCLK flop only serves the rising-edge detect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            din_s1  <= 1'b0;
            din_s2  <= 1'b0;
            lr_prev <= 1'b0;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            lr_s1   <= LRCLK;
            lr_s2   <= lr_s1;
            din_s1  <= Din;
            din_s2  <= din_s1;
            if (sclk_rise) lr_prev <= lr_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign lr_edge   = lr_s2 != lr_prev;
    assign word      = {sr[SAMPLE_W-2:0], din_s2};
    assign fsm_state = state;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        shift_en     = 1'b0;
        clear_bitcnt = 1'b0;
        word_done    = 1'b0;
        truncate     = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else if (sclk_rise) begin
            case (state)
                IDLE: begin
                    if (lr_edge && !lr_s2) state_next = DELAY;
                end
                DELAY: begin
                    state_next   = SHIFT;
                    clear_bitcnt = 1'b1;
                end
                SHIFT: begin
                    if (lr_edge) begin
                        truncate   = 1'b1;
                        state_next = DELAY;
                    end else begin
                        shift_en = 1'b1;
                        if (bitcnt == BITCNT_W'(SAMPLE_W - 1)) begin
                            word_done  = 1'b1;
                            state_next = PAD;
                        end
                    end
                end
                PAD: begin
                    if (lr_edge) state_next = DELAY;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A right word only forms a pair with a left word captured earlier in the same frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bitcnt     <= '0;
            sr         <= '0;
            left_hold  <= '0;
            left_valid <= 1'b0;
            push_req   <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (clear_bitcnt)  bitcnt <= '0;
            else if (shift_en) bitcnt <= bitcnt + BITCNT_W'(1);
            if (shift_en) sr <= word;
            if (!enable) begin
                left_valid <= 1'b0;
            end else if (word_done) begin
                if (!lr_s2) begin
                    left_hold  <= word;
                    left_valid <= 1'b1;
                end else if (left_valid) begin
                    push_req   <= 1'b1;
                    left_valid <= 1'b0;
                end
            end
        end
    end

    assign ctrl_wr      = bus.ram_write && (bus.ram_address == REG_CTRL);
    assign flush        = ctrl_wr && bus.ram_writedata[CTRL_FLUSH];
    assign pop          = bus.ram_read && (bus.ram_address == REG_RIGHT);
    assign unused_wdata = ^bus.ram_writedata[31:4];

    stereo_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push_req),
        .push_data ({left_hold, sr}),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .push_ok   (fifo_push_ok),
        .drop      (fifo_drop)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            enable <= 1'b0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
            frames <= '0;
        end else begin
            if (ctrl_wr) enable <= bus.ram_writedata[CTRL_ENABLE];
            if (fifo_drop)                                   ovf <= 1'b1;
            else if (ctrl_wr && bus.ram_writedata[CTRL_OVF]) ovf <= 1'b0;
            if (truncate)                                     ferr <= 1'b1;
            else if (ctrl_wr && bus.ram_writedata[CTRL_FERR]) ferr <= 1'b0;
            if (fifo_push_ok) frames <= frames + 32'd1;
        end
    end

    always_comb begin
        bus.ram_readdata = '0;
        case (bus.ram_address)
            REG_CTRL: begin
                bus.ram_readdata[CTRL_ENABLE]               = enable;
                bus.ram_readdata[CTRL_OVF]                  = ovf;
                bus.ram_readdata[CTRL_FERR]                 = ferr;
                bus.ram_readdata[STAT_FILL_LSB +: CNT_W]    = fifo_count;
                bus.ram_readdata[STAT_EMPTY]                = fifo_empty;
            end
            REG_LEFT: begin
                if (!fifo_empty) bus.ram_readdata = left_justify(fifo_head[PAIR_W-1 -: SAMPLE_W]);
            end
            REG_RIGHT: begin
                if (!fifo_empty) bus.ram_readdata = left_justify(fifo_head[SAMPLE_W-1:0]);
            end
            REG_FRAMES: bus.ram_readdata = frames;
            default:    bus.ram_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames at SCLK = CLK/8 with 32-bit slots.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      sclk = 1'b0;
    logic      lrclk = 1'b1;
    logic      din = 1'b1;
    rx_state_t fsm_state;
    int        n_checks = 0;
    int        n_fail = 0;
    logic [31:0] rd;

    i2s_rx_if bus();

    i2s_rx dut (
        .CLK       (clk),
        .RESET     (rst),
        .SCLK      (sclk),
        .LRCLK     (lrclk),
        .Din       (din),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] stat(input bit en, input bit ov, input bit fe, input int fill);
        return {25'd0, (fill == 0), 3'(fill), fe, ov, en};
    endfunction

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus.ram_address = a;
        #1;
        d = bus.ram_readdata;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.ram_address   = a;
        bus.ram_writedata = d;
        bus.ram_write     = 1'b1;
        @(negedge clk);
        bus.ram_write     = 1'b0;
    endtask

    task automatic pop_pair();
        bus.ram_address = REG_RIGHT;
        bus.ram_read    = 1'b1;
        @(negedge clk);
        bus.ram_read    = 1'b0;
    endtask

    // One SCLK period; with do_pop the pop strobe lands on the push edge of this bit.
    task automatic send_bit(input logic lr, input logic d, input bit do_pop);
        sclk  = 1'b0;
        lrclk = lr;
        din   = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        if (do_pop) begin
            repeat (3) @(negedge clk);
            bus.ram_address = REG_RIGHT;
            bus.ram_read    = 1'b1;
            @(negedge clk);
            bus.ram_read    = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    // Slot bit 0 carries the LRCLK change, bit 1 is the delay bit, bits 2..25 the word.
    task automatic send_slot(input logic lr, input logic [23:0] w, input int nbits, input bit pop_last);
        for (int j = 0; j < nbits; j++) begin
            if (j >= 2 && j < 26) send_bit(lr, w[25 - j], pop_last && (j == 25));
            else                  send_bit(lr, 1'b1, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32, 1'b0);
        send_slot(1'b1, r, 32, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== 32'h40) begin n_fail++; $display("FAIL reset_ctrl: got %h required %h", rd, 32'h40); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_left: got %h required %h", rd, 32'h0); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_right: got %h required %h", rd, 32'h0); end
        rd_reg(REG_FRAMES, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_frames: got %h required %h", rd, 32'h0); end
        n_checks++; if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", fsm_state, IDLE); end
        send_slot(1'b1, 24'h0, 4, 1'b0);
    endtask

    task automatic test_basic();
        wr_reg(REG_CTRL, 32'h1);
        send_frame(24'hABCDEF, 24'h123456);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 1)) begin n_fail++; $display("FAIL basic_ctrl: got %h required %h", rd, stat(1, 0, 0, 1)); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'hABCDEF00) begin n_fail++; $display("FAIL basic_left: got %h required %h", rd, 32'hABCDEF00); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'h12345600) begin n_fail++; $display("FAIL basic_right: got %h required %h", rd, 32'h12345600); end
        pop_pair();
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 0)) begin n_fail++; $display("FAIL basic_empty: got %h required %h", rd, stat(1, 0, 0, 0)); end
        rd_reg(REG_FRAMES, rd);
        n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL basic_frames: got %h required %h", rd, 32'd1); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) send_frame(24'h111111 * i, 24'hFEDC00 | 24'(i));
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 1, 0, 4)) begin n_fail++; $display("FAIL ovf_ctrl: got %h required %h", rd, stat(1, 1, 0, 4)); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'h11111100) begin n_fail++; $display("FAIL ovf_head_left: got %h required %h", rd, 32'h11111100); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'hFEDC0100) begin n_fail++; $display("FAIL ovf_head_right: got %h required %h", rd, 32'hFEDC0100); end
        rd_reg(REG_FRAMES, rd);
        n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL ovf_frames: got %h required %h", rd, 32'd5); end
        wr_reg(REG_CTRL, 32'h2);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(0, 0, 0, 4)) begin n_fail++; $display("FAIL ovf_clear: got %h required %h", rd, stat(0, 0, 0, 4)); end
        wr_reg(REG_CTRL, 32'h1);
    endtask

    task automatic test_push_pop_full();
        send_slot(1'b0, 24'h666666, 32, 1'b0);
        send_slot(1'b1, 24'hFEDC06, 32, 1'b1);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 4)) begin n_fail++; $display("FAIL pp_ctrl: got %h required %h", rd, stat(1, 0, 0, 4)); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'h22222200) begin n_fail++; $display("FAIL pp_head: got %h required %h", rd, 32'h22222200); end
        rd_reg(REG_FRAMES, rd);
        n_checks++; if (rd !== 32'd6) begin n_fail++; $display("FAIL pp_frames: got %h required %h", rd, 32'd6); end
        repeat (3) pop_pair();
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'h66666600) begin n_fail++; $display("FAIL pp_tail_left: got %h required %h", rd, 32'h66666600); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'hFEDC0600) begin n_fail++; $display("FAIL pp_tail_right: got %h required %h", rd, 32'hFEDC0600); end
        pop_pair();
        pop_pair();
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 0)) begin n_fail++; $display("FAIL pp_drained: got %h required %h", rd, stat(1, 0, 0, 0)); end
    endtask

    task automatic test_enable_mid_right();
        wr_reg(REG_CTRL, 32'h0);
        send_slot(1'b0, 24'hAAAAAA, 32, 1'b0);
        fork
            send_slot(1'b1, 24'hBBBBBB, 32, 1'b0);
            begin
                repeat (40) @(negedge clk);
                wr_reg(REG_CTRL, 32'h1);
            end
        join
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 0)) begin n_fail++; $display("FAIL en_partial: got %h required %h", rd, stat(1, 0, 0, 0)); end
        send_frame(24'h13579B, 24'h2468AC);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 1)) begin n_fail++; $display("FAIL en_ctrl: got %h required %h", rd, stat(1, 0, 0, 1)); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'h13579B00) begin n_fail++; $display("FAIL en_left: got %h required %h", rd, 32'h13579B00); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'h2468AC00) begin n_fail++; $display("FAIL en_right: got %h required %h", rd, 32'h2468AC00); end
        pop_pair();
    endtask

    task automatic test_truncate();
        send_slot(1'b0, 24'hDEADBE, 12, 1'b0);
        send_slot(1'b1, 24'h777777, 32, 1'b0);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 1, 0)) begin n_fail++; $display("FAIL trunc_ctrl: got %h required %h", rd, stat(1, 0, 1, 0)); end
        send_frame(24'hC0FFEE, 24'h0BADF0);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 1, 1)) begin n_fail++; $display("FAIL trunc_next_ctrl: got %h required %h", rd, stat(1, 0, 1, 1)); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'hC0FFEE00) begin n_fail++; $display("FAIL trunc_left: got %h required %h", rd, 32'hC0FFEE00); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'h0BADF000) begin n_fail++; $display("FAIL trunc_right: got %h required %h", rd, 32'h0BADF000); end
        wr_reg(REG_CTRL, 32'h5);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 1)) begin n_fail++; $display("FAIL trunc_clear: got %h required %h", rd, stat(1, 0, 0, 1)); end
        pop_pair();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(24'h0A0B0C, 24'h0D0E0F);
        send_frame(24'h102030, 24'h405060);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 2)) begin n_fail++; $display("FAIL rst_pre_fill: got %h required %h", rd, stat(1, 0, 0, 2)); end
        fork
            send_frame(24'h999999, 24'h888888);
            begin
                repeat (96) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                rd_reg(REG_CTRL, rd);
                n_checks++; if (rd !== 32'h40) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h required %h", rd, 32'h40); end
                rd_reg(REG_FRAMES, rd);
                n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_frames: got %h required %h", rd, 32'h0); end
            end
        join
        wr_reg(REG_CTRL, 32'h1);
        send_frame(24'h5A5A5A, 24'hA5A5A5);
        rd_reg(REG_CTRL, rd);
        n_checks++; if (rd !== stat(1, 0, 0, 1)) begin n_fail++; $display("FAIL rst_after_ctrl: got %h required %h", rd, stat(1, 0, 0, 1)); end
        rd_reg(REG_LEFT, rd);
        n_checks++; if (rd !== 32'h5A5A5A00) begin n_fail++; $display("FAIL rst_after_left: got %h required %h", rd, 32'h5A5A5A00); end
        rd_reg(REG_RIGHT, rd);
        n_checks++; if (rd !== 32'hA5A5A500) begin n_fail++; $display("FAIL rst_after_right: got %h required %h", rd, 32'hA5A5A500); end
        rd_reg(REG_FRAMES, rd);
        n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL rst_after_frames: got %h required %h", rd, 32'd1); end
    endtask

    initial begin
        bus.ram_address   = 2'd0;
        bus.ram_read      = 1'b0;
        bus.ram_write     = 1'b0;
        bus.ram_writedata = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_enable_mid_right();
        test_truncate();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
